// File: rtl/cellrv32_cpu_cp_fpu32_f2i_arb.sv
// Round-robin arbiter that shares one multi-cycle float-to-int converter between NREQ requesters.
// Latches one request, starts the converter, holds its operands until done and returns one response.
module cellrv32_cpu_cp_fpu32_f2i_arb #(
    parameter int NREQ  = 2,
    parameter int TAG_W = 4,
    parameter int TMO   = 63
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic [NREQ-1:0]         req_valid_i,
    output logic [NREQ-1:0]         req_ready_o,
    input  logic [3*NREQ-1:0]       req_rmode_i,
    input  logic [NREQ-1:0]         req_funct_i,
    input  logic [NREQ-1:0]         req_sign_i,
    input  logic [8*NREQ-1:0]       req_exp_i,
    input  logic [23*NREQ-1:0]      req_mant_i,
    input  logic [10*NREQ-1:0]      req_class_i,
    input  logic [TAG_W*NREQ-1:0]   req_tag_i,
    output logic                    cvt_start_o,
    output logic [2:0]              cvt_rmode_o,
    output logic                    cvt_funct_o,
    output logic                    cvt_sign_o,
    output logic [7:0]              cvt_exp_o,
    output logic [22:0]             cvt_mant_o,
    output logic [9:0]              cvt_class_o,
    input  logic [31:0]             cvt_result_i,
    input  logic [4:0]              cvt_flags_i,
    input  logic                    cvt_done_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [1:0]              rsp_id_o,
    output logic [TAG_W-1:0]        rsp_tag_o,
    output logic [31:0]             rsp_result_o,
    output logic [4:0]              rsp_flags_o,
    output logic                    rsp_err_o
);
    localparam int WD_W = $clog2(TMO + 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_t;

    state_t            r_state;
    logic [1:0]        r_ptr;
    logic [1:0]        r_id;
    logic [WD_W-1:0]   r_wdog;
    logic [2:0]        r_rmode;
    logic              r_funct;
    logic              r_sign;
    logic [7:0]        r_exp;
    logic [22:0]       r_mant;
    logic [9:0]        r_class;
    logic [TAG_W-1:0]  r_tag;
    logic [31:0]       r_result;
    logic [4:0]        r_flags;
    logic              r_err;

    logic              w_any;
    logic [1:0]        w_gnt;
    logic              w_accept;
    logic              w_wdog_tc;

    // First valid requester at/after ptr+1, wrapping.
    always_comb begin
        w_any = 1'b0;
        w_gnt = 2'd0;
        for (int i = 1; i <= NREQ; i++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!w_any && (k == (int'(r_ptr) + i) % NREQ) && req_valid_i[k]) begin
                    w_any = 1'b1;
                    w_gnt = 2'(k);
                end
            end
        end
    end

    assign w_accept  = (r_state == S_IDLE) && !flush_i && w_any;
    assign w_wdog_tc = (r_wdog <= WD_W'(1));

    always_comb begin
        req_ready_o = '0;
        for (int k = 0; k < NREQ; k++) begin
            req_ready_o[k] = w_accept && (w_gnt == 2'(k));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_ptr    <= 2'd0;
            r_id     <= 2'd0;
            r_wdog   <= '0;
            r_rmode  <= '0;
            r_funct  <= 1'b0;
            r_sign   <= 1'b0;
            r_exp    <= '0;
            r_mant   <= '0;
            r_class  <= '0;
            r_tag    <= '0;
            r_result <= '0;
            r_flags  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        for (int k = 0; k < NREQ; k++) begin
                            if (w_gnt == 2'(k)) begin
                                r_rmode <= req_rmode_i[3*k +: 3];
                                r_funct <= req_funct_i[k];
                                r_sign  <= req_sign_i[k];
                                r_exp   <= req_exp_i[8*k +: 8];
                                r_mant  <= req_mant_i[23*k +: 23];
                                r_class <= req_class_i[10*k +: 10];
                                r_tag   <= req_tag_i[TAG_W*k +: TAG_W];
                            end
                        end
                        r_ptr   <= w_gnt;
                        r_id    <= w_gnt;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wdog  <= WD_W'(TMO);
                    r_state <= flush_i ? S_IDLE : S_WAIT;
                end
                S_WAIT: begin
                    r_wdog <= r_wdog - WD_W'(1);
                    // Flush beats done, done beats the watchdog.
                    if (flush_i) begin
                        r_state <= S_DRAIN;
                    end else if (cvt_done_i) begin
                        r_result <= cvt_result_i;
                        r_flags  <= cvt_flags_i;
                        r_err    <= 1'b0;
                        r_state  <= S_RESP;
                    end else if (w_wdog_tc) begin
                        r_result <= '0;
                        r_flags  <= '0;
                        r_err    <= 1'b1;
                        r_state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (flush_i || rsp_ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (r_wdog != '0) begin
                        r_wdog <= r_wdog - WD_W'(1);
                    end
                    if (cvt_done_i || w_wdog_tc) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cvt_start_o  = (r_state == S_ISSUE) && !flush_i;
    assign cvt_rmode_o  = r_rmode;
    assign cvt_funct_o  = r_funct;
    assign cvt_sign_o   = r_sign;
    assign cvt_exp_o    = r_exp;
    assign cvt_mant_o   = r_mant;
    assign cvt_class_o  = r_class;
    assign rsp_valid_o  = (r_state == S_RESP);
    assign rsp_id_o     = r_id;
    assign rsp_tag_o    = r_tag;
    assign rsp_result_o = r_result;
    assign rsp_flags_o  = r_flags;
    assign rsp_err_o    = r_err;

endmodule

// File: tb/tb_cellrv32_cpu_cp_fpu32_f2i_arb.sv
// Scoreboard bench for the shared F2I arbiter with a behavioural converter stub.
// Requester queues feed the DUT; a monitor pops hand-computed expectations on each response handshake.
module tb_cellrv32_cpu_cp_fpu32_f2i_arb;
    localparam int NREQ  = 2;
    localparam int TAG_W = 4;
    localparam int TMO   = 63;

    logic              clk = 1'b0;
    logic              rst_i, flush_i;
    logic [NREQ-1:0]   req_valid, req_ready_o, req_funct, req_sign;
    logic [3*NREQ-1:0] req_rmode;
    logic [8*NREQ-1:0] req_exp;
    logic [23*NREQ-1:0] req_mant;
    logic [10*NREQ-1:0] req_class;
    logic [TAG_W*NREQ-1:0] req_tag;
    logic              cvt_start_o, cvt_funct_o, cvt_sign_o;
    logic [2:0]        cvt_rmode_o;
    logic [7:0]        cvt_exp_o;
    logic [22:0]       cvt_mant_o;
    logic [9:0]        cvt_class_o;
    logic [31:0]       cvt_result;
    logic [4:0]        cvt_flags;
    logic              cvt_done;
    logic              rsp_valid_o, rsp_ready, rsp_err_o;
    logic [1:0]        rsp_id_o;
    logic [TAG_W-1:0]  rsp_tag_o;
    logic [31:0]       rsp_result_o;
    logic [4:0]        rsp_flags_o;

    typedef struct packed {
        logic [2:0]  rmode;
        logic        funct;
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
        logic [9:0]  cls;
        logic [3:0]  tag;
    } req_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [3:0]  tag;
        logic [31:0] res;
        logic [4:0]  flg;
        logic        err;
    } exp_t;

    req_t q0[$];
    req_t q1[$];
    exp_t sb[$];

    int checks = 0, failures = 0;
    int cyc = 0, n_starts = 0, n_rsp = 0, last_start = 0, first_valid = 0;
    int cvt_lat = 5;
    logic prev_v = 1'b0;

    always #5 clk = ~clk;

    cellrv32_cpu_cp_fpu32_f2i_arb #(.NREQ(NREQ), .TAG_W(TAG_W), .TMO(TMO)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_rmode_i(req_rmode),
        .req_funct_i(req_funct), .req_sign_i(req_sign), .req_exp_i(req_exp),
        .req_mant_i(req_mant), .req_class_i(req_class), .req_tag_i(req_tag),
        .cvt_start_o(cvt_start_o), .cvt_rmode_o(cvt_rmode_o), .cvt_funct_o(cvt_funct_o),
        .cvt_sign_o(cvt_sign_o), .cvt_exp_o(cvt_exp_o), .cvt_mant_o(cvt_mant_o),
        .cvt_class_o(cvt_class_o), .cvt_result_i(cvt_result), .cvt_flags_i(cvt_flags),
        .cvt_done_i(cvt_done), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
        .rsp_id_o(rsp_id_o), .rsp_tag_o(rsp_tag_o), .rsp_result_o(rsp_result_o),
        .rsp_flags_o(rsp_flags_o), .rsp_err_o(rsp_err_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic req_t mk(input logic [2:0] rm, input logic s, input logic [7:0] e,
                                input logic [22:0] m, input logic [9:0] c, input logic [3:0] t);
        req_t r;
        r.rmode = rm; r.funct = 1'b0; r.sign = s; r.exp = e; r.mant = m; r.cls = c; r.tag = t;
        return r;
    endfunction

    function automatic exp_t ex(input logic [1:0] id, input logic [3:0] t, input logic [31:0] res,
                                input logic [4:0] f, input logic e);
        exp_t x;
        x.id = id; x.tag = t; x.res = res; x.flg = f; x.err = e;
        return x;
    endfunction

    // Converter stub: normal operands with exponent 127..150 only; NX is flag bit 0.
    function automatic logic [36:0] f2i(input logic [2:0] rm, input logic s, input logic [7:0] e,
                                        input logic [22:0] m);
        int sh;
        logic [23:0] full, ip, rem, half;
        logic up;
        logic [31:0] r;
        full = {1'b1, m};
        sh   = 150 - int'(e);
        if (sh < 0 || sh > 23) return '0;
        ip   = full >> sh;
        rem  = full - (ip << sh);
        half = (sh > 0) ? (24'd1 << (sh - 1)) : 24'd0;
        case (rm)
            3'd0: up = (sh > 0) && ((rem > half) || ((rem == half) && ip[0]));
            3'd2: up = s && (rem != 0);
            3'd3: up = !s && (rem != 0);
            3'd4: up = (sh > 0) && (rem >= half);
            default: up = 1'b0;
        endcase
        r = 32'(ip) + 32'(up);
        if (s) r = -r;
        return {4'b0, (rem != 0), r};
    endfunction

    task automatic present(input int k, input req_t r, input logic v);
        req_valid[k]             = v;
        req_rmode[3*k +: 3]      = r.rmode;
        req_funct[k]             = r.funct;
        req_sign[k]              = r.sign;
        req_exp[8*k +: 8]        = r.exp;
        req_mant[23*k +: 23]     = r.mant;
        req_class[10*k +: 10]    = r.cls;
        req_tag[TAG_W*k +: TAG_W] = r.tag;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Requester driver: hold head of each queue valid until accepted.
    initial begin
        logic [NREQ-1:0] acc;
        req_valid = '0; req_rmode = '0; req_funct = '0; req_sign = '0;
        req_exp = '0; req_mant = '0; req_class = '0; req_tag = '0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready_o;
            @(posedge clk);
            #1;
            if (acc[0] && q0.size() > 0) void'(q0.pop_front());
            if (acc[1] && q1.size() > 0) void'(q1.pop_front());
            if (q0.size() > 0) present(0, q0[0], 1'b1); else present(0, '0, 1'b0);
            if (q1.size() > 0) present(1, q1[0], 1'b1); else present(1, '0, 1'b0);
        end
    end

    initial begin
        int lat;
        cvt_done = 1'b0; cvt_result = '0; cvt_flags = '0;
        forever begin
            @(negedge clk);
            if (cvt_start_o && cvt_lat > 0) begin
                lat = cvt_lat;
                repeat (lat) @(negedge clk);
                {cvt_flags, cvt_result} = f2i(cvt_rmode_o, cvt_sign_o, cvt_exp_o, cvt_mant_o);
                cvt_done = 1'b1;
                @(negedge clk);
                cvt_done = 1'b0;
            end
        end
    end

    // Monitor: start counting, latency markers and scoreboard pops.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (cvt_start_o) begin
            n_starts++;
            last_start = cyc;
        end
        if (rsp_valid_o && !prev_v) first_valid = cyc;
        prev_v = rsp_valid_o;
        if (rsp_valid_o && rsp_ready) begin
            n_rsp++;
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 64'({rsp_id_o, rsp_tag_o, rsp_result_o, rsp_flags_o, rsp_err_o}), 64'hDEAD);
            end else begin
                e = sb.pop_front();
                chk("rsp", 64'({rsp_id_o, rsp_tag_o, rsp_result_o, rsp_flags_o, rsp_err_o}), 64'(e));
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_out", 64'({rsp_valid_o, cvt_start_o, req_ready_o, rsp_result_o, rsp_err_o, cvt_exp_o, rsp_tag_o}), 64'd0);
        @(posedge clk);
        #1 rst_i = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        logic ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && q0.size() == 0 && q1.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 64'(ok), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input string name, input int budget);
        int s0 = n_starts;
        logic ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (n_starts != s0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 64'(ok), 64'd1);
    endtask

    localparam logic [9:0] C_PN = 10'h040;
    localparam logic [9:0] C_NN = 10'h002;

    initial begin
        int s0, r0;
        logic stable;
        rst_i = 1'b1; flush_i = 1'b0; rsp_ready = 1'b1;
        do_reset();

        // 1.0f RNE on requester 0 only
        cvt_lat = 5;
        s0 = n_starts;
        sb.push_back(ex(2'd0, 4'h1, 32'd1, 5'd0, 1'b0));
        q0.push_back(mk(3'd0, 1'b0, 8'd127, 23'd0, C_PN, 4'h1));
        wait_idle("t1_done", 200);
        chk("t1_starts", 64'(n_starts - s0), 64'd1);
        chk("t1_latency", 64'(first_valid - last_start), 64'd6);

        // both requesters valid together: grants 1,0,1,0
        do_reset();
        s0 = n_starts;
        sb.push_back(ex(2'd1, 4'hC, 32'hFFFF_FFFE, 5'd1, 1'b0));
        sb.push_back(ex(2'd0, 4'hA, 32'd1, 5'd0, 1'b0));
        sb.push_back(ex(2'd1, 4'hD, 32'd2, 5'd1, 1'b0));
        sb.push_back(ex(2'd0, 4'hB, 32'd3, 5'd0, 1'b0));
        q0.push_back(mk(3'd0, 1'b0, 8'd127, 23'd0, C_PN, 4'hA));
        q0.push_back(mk(3'd0, 1'b0, 8'd128, 23'h400000, C_PN, 4'hB));
        q1.push_back(mk(3'd0, 1'b1, 8'd127, 23'h400000, C_NN, 4'hC));
        q1.push_back(mk(3'd1, 1'b0, 8'd128, 23'h200000, C_PN, 4'hD));
        wait_idle("t2_done", 400);
        chk("t2_starts", 64'(n_starts - s0), 64'd4);

        // 2.5f with RNE then RMM, single-cycle converter
        cvt_lat = 1;
        sb.push_back(ex(2'd0, 4'h3, 32'd2, 5'd1, 1'b0));
        sb.push_back(ex(2'd0, 4'h4, 32'd3, 5'd1, 1'b0));
        q0.push_back(mk(3'd0, 1'b0, 8'd128, 23'h200000, C_PN, 4'h3));
        q0.push_back(mk(3'd4, 1'b0, 8'd128, 23'h200000, C_PN, 4'h4));
        wait_idle("t3_done", 200);
        chk("t3_latency", 64'(first_valid - last_start), 64'd2);

        // response back-pressure for 10 cycles with another request pending
        cvt_lat = 5;
        rsp_ready = 1'b0;
        sb.push_back(ex(2'd0, 4'h5, 32'd1, 5'd0, 1'b0));
        q0.push_back(mk(3'd0, 1'b0, 8'd127, 23'd0, C_PN, 4'h5));
        stable = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid_o) begin
                stable = 1'b1;
                break;
            end
        end
        chk("t4_rsp_seen", 64'(stable), 64'd1);
        s0 = n_starts;
        sb.push_back(ex(2'd1, 4'h6, 32'd3, 5'd0, 1'b0));
        q1.push_back(mk(3'd0, 1'b0, 8'd128, 23'h400000, C_PN, 4'h6));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(rsp_valid_o && rsp_tag_o == 4'h5 && rsp_result_o == 32'd1 && rsp_id_o == 2'd0
                  && req_ready_o == '0 && n_starts == s0))
                stable = 1'b0;
        end
        chk("t4_stall_hold", 64'(stable), 64'd1);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_idle("t4_done", 200);

        // flush during WAIT: response dropped, next request served after the stale done
        cvt_lat = 20;
        r0 = n_rsp;
        q0.push_back(mk(3'd0, 1'b0, 8'd127, 23'd0, C_PN, 4'h7));
        wait_start("t5_start", 50);
        repeat (3) @(posedge clk);
        #1 flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0;
        cvt_lat = 3;
        sb.push_back(ex(2'd1, 4'h8, 32'd3, 5'd1, 1'b0));
        q1.push_back(mk(3'd4, 1'b0, 8'd128, 23'h200000, C_PN, 4'h8));
        wait_idle("t5_done", 200);
        chk("t5_rsp_count", 64'(n_rsp - r0), 64'd1);

        // watchdog: converter never answers
        cvt_lat = 0;
        sb.push_back(ex(2'd0, 4'h9, 32'd0, 5'd0, 1'b1));
        q0.push_back(mk(3'd0, 1'b0, 8'd127, 23'd0, C_PN, 4'h9));
        wait_idle("t6_done", 300);
        chk("t6_latency", 64'(first_valid - last_start), 64'(TMO + 1));

        // reset mid-WAIT: stray done afterwards must be ignored
        cvt_lat = 10;
        r0 = n_rsp;
        q0.push_back(mk(3'd0, 1'b0, 8'd127, 23'd0, C_PN, 4'hA));
        wait_start("t7_start", 50);
        repeat (2) @(posedge clk);
        do_reset();
        repeat (15) @(posedge clk);
        chk("t7_no_rsp", 64'(n_rsp - r0), 64'd0);
        cvt_lat = 2;
        sb.push_back(ex(2'd1, 4'hB, 32'd3, 5'd0, 1'b0));
        q1.push_back(mk(3'd0, 1'b0, 8'd128, 23'h400000, C_PN, 4'hB));
        wait_idle("t7_done", 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
